// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, flag bit positions (same as the ALU) and FSM states.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_DIVS = 2'd3;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_POS   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negation (abs value / sign restore).
// Ports: val_i operand, neg_i negate request, res_o result.
module muldiv_sign #(
    parameter int W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative N-bit multiply/divide unit (shift-add / restoring).
// Ports: CLK, RESET_N, a, b, op, start in; busy, finished, result, high, flags out.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N         = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic         start,
    output logic         busy,
    output logic         finished,
    output logic [N-1:0] result,
    output logic [N-1:0] high,
    output logic [3:0]   flags
);

    localparam int CW = $clog2(N) + 1;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_d;
    logic [N-1:0]   opnd_q;
    logic           div_q;
    logic           sgn_q;
    logic           qneg_q;
    logic           rneg_q;
    logic           dz_q;
    logic           busy_q;
    logic           fin_q;
    logic [N-1:0]   res_q;
    logic [N-1:0]   high_q;
    logic [3:0]     flags_q;

    // Launch decode
    logic         in_div;
    logic         in_sgn;
    logic         in_dz;
    logic [N-1:0] abs_a;
    logic [N-1:0] abs_b;

    assign in_div = (op == OP_DIV) || (op == OP_DIVS);
    assign in_sgn = SIGNED_EN && ((op == OP_MULS) || (op == OP_DIVS));
    assign in_dz  = in_div && (b == '0);

    muldiv_sign #(.W(N)) u_abs_a (
        .val_i (a),
        .neg_i (in_sgn && a[N-1]),
        .res_o (abs_a)
    );

    muldiv_sign #(.W(N)) u_abs_b (
        .val_i (b),
        .neg_i (in_sgn && b[N-1]),
        .res_o (abs_b)
    );

    // One iteration step. Multiply keeps the multiplier in the low half
    // and shifts right; divide keeps the dividend low and shifts left.
    logic [N:0] add_s;
    logic [N:0] rem_s;
    logic [N:0] sub_s;

    always_comb begin
        acc_d = acc_q;
        add_s = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_s = {acc_q[2*N-1:N], acc_q[N-1]};
        sub_s = rem_s - {1'b0, opnd_q};
        if (div_q) begin
            if (!sub_s[N]) begin
                acc_d = {sub_s[N-1:0], acc_q[N-2:0], 1'b1};
            end else begin
                acc_d = {rem_s[N-1:0], acc_q[N-2:0], 1'b0};
            end
        end else begin
            acc_d = {add_s, acc_q[N-1:1]};
        end
    end

    // Sign correction: full product or quotient, and remainder.
    logic [2*N-1:0] fix_in;
    logic [2*N-1:0] fix_lo;
    logic [N-1:0]   fix_hi;
    logic [N-1:0]   fin_lo;
    logic [N-1:0]   fin_hi;

    assign fix_in = div_q ? {{N{1'b0}}, acc_q[N-1:0]} : acc_q;

    muldiv_sign #(.W(2*N)) u_fix_lo (
        .val_i (fix_in),
        .neg_i (qneg_q),
        .res_o (fix_lo)
    );

    muldiv_sign #(.W(N)) u_fix_hi (
        .val_i (acc_q[2*N-1:N]),
        .neg_i (rneg_q),
        .res_o (fix_hi)
    );

    assign fin_lo = fix_lo[N-1:0];
    assign fin_hi = div_q ? fix_hi : fix_lo[2*N-1:N];

    logic [3:0] fix_flags;
    logic [3:0] dz_flags;
    logic       f_zero;

    always_comb begin
        fix_flags = '0;
        dz_flags  = '0;
        f_zero    = (fin_lo == '0) && (div_q || (fin_hi == '0));
        fix_flags[FLAG_ZERO]  = f_zero;
        fix_flags[FLAG_CARRY] = !div_q && !sgn_q && (fin_hi != '0);
        // Signed quotient overflows only for most-negative / -1:
        // magnitude 2^(N-1) with a positive sign.
        if (div_q) begin
            fix_flags[FLAG_OVF] = sgn_q && !qneg_q && acc_q[N-1];
        end else begin
            fix_flags[FLAG_OVF] = sgn_q && (fin_hi != {N{fin_lo[N-1]}});
        end
        fix_flags[FLAG_POS] = !f_zero
            && !(sgn_q && (div_q ? fin_lo[N-1] : fin_hi[N-1]));
        dz_flags[FLAG_OVF] = 1'b1;
        dz_flags[FLAG_POS] = !sgn_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            res_q   <= '0;
            high_q  <= '0;
            flags_q <= '0;
        end else begin
            fin_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        div_q  <= in_div;
                        sgn_q  <= in_sgn;
                        dz_q   <= in_dz;
                        qneg_q <= in_sgn && (a[N-1] ^ b[N-1]);
                        rneg_q <= in_sgn && in_div && a[N-1];
                        opnd_q <= in_div ? abs_b : abs_a;
                        cnt_q  <= CW'(N);
                        if (in_dz) begin
                            // Raw dividend kept for the remainder output.
                            acc_q   <= {{N{1'b0}}, a};
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= {{N{1'b0}}, in_div ? abs_a : abs_b};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    res_q   <= fin_lo;
                    high_q  <= fin_hi;
                    flags_q <= fix_flags;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (dz_q) begin
                        res_q   <= '1;
                        high_q  <= acc_q[N-1:0];
                        flags_q <= dz_flags;
                    end
                    fin_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign finished = fin_q;
    assign result   = res_q;
    assign high     = high_q;
    assign flags    = flags_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit; successor to the ALU's built-in multi-cycle MUL/DIV path. It adds generic width, signed and unsigned modes, explicit busy status, divide-by-zero and overflow reporting, and a fixed, documented latency. It sits beside the ALU in the CPU datapath. The control unit launches an operation with `start` and stalls until `finished`.

## Interface

- `N`, 16: operand/result width, ≥4.
- `SIGNED_EN`, 1: 1 enables signed ops; 0 makes signed op codes behave as their unsigned forms.

- `CLK`  in  1  system clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `a`  in  N  first operand (multiplicand / dividend).
- `b`  in  N  second operand (multiplier / divisor).
- `op`  in  2  0=MUL, 1=MULS, 2=DIV, 3=DIVS.
- `start`  in  1  launch request, sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `finished` pulses.
- `finished`  out  1  one-cycle pulse; results valid from this cycle.
- `result`  out  N  low product half / quotient.
- `high`  out  N  high product half / remainder.
- `flags`  out  4  bit3 POSITIVE, bit2 OVERFLOW, bit1 CARRY, bit0 ZERO.

## Operation

- FSM states:
  - IDLE: on `start`=1, latch `a`, `b`, `op`. Signed ops take absolute values and record the result/remainder signs. Go to CALC, or to DONE on divide-by-zero.
  - CALC: N cycles, one bit per cycle. Multiply is shift-add into a 2N accumulator. Divide is restoring, one quotient bit per cycle.
  - FIX: one cycle. Apply sign correction, compute flags and register the outputs.
  - DONE: one cycle. `finished`=1, then return to IDLE.
- Outputs and flags hold their last values until the next FIX or DONE writes them.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b==0, DIV or DIVS):
  - `result` = all ones, `high` = `a`.
  - OVERFLOW=1, CARRY=0.
- DIVS most-negative ÷ −1: `result` = 2^(N−1), `high` = 0, OVERFLOW=1.
- Flags:
  - ZERO: `result`==0, and for MUL/MULS also `high`==0.
  - CARRY: MUL only, set when `high`!=0.
  - OVERFLOW: for MULS, `high` is not the sign extension of `result`. For divides, the cases listed above.
  - POSITIVE: ZERO=0 and the MSB of the full result is 0. For unsigned ops this means ZERO=0 only.
- `start` while `busy` is ignored. It is never queued.
- `busy` stays low while in IDLE.

## Timing

- All outputs reset to 0 and the state resets to IDLE. Reset is asynchronous and takes effect immediately, including mid-operation; the in-flight operation is discarded.
- `start` is accepted at edge 0.
  - Normal op: `finished` rises after edge N+2, i.e. N+2 cycles of latency. `busy` is high for the N+2 cycles from edge 0.
  - Divide-by-zero: `finished` rises after edge 1; `busy` is high for 1 cycle.
- `finished` is high for exactly one cycle. A new `start` can be accepted in the cycle after `finished`, back-to-back with no dead cycle.
- Operands may change freely after the accepting edge.

## Structure

- Shared package `muldiv_pkg` holds:
  - op-code localparams (OP_MUL, OP_MULS, OP_DIV, OP_DIVS);
  - flag indices (POSITIVE=3, OVERFLOW=2, CARRY=1, ZERO=0), matching the ALU;
  - the FSM state encoding.
- One sub-module is natural: `muldiv_sign`. It is combinational, parametrised by N, and does the conditional absolute value and negation. It is instantiated for operand preparation and for the FIX stage.
- The iteration counter is $clog2(N)+1 bits wide. The datapath uses a 2N-bit accumulator/remainder register.

## Test plan

All scenarios use N=16.

- MUL a=300, b=500 → `high`=0x0002, `result`=0x49F0, CARRY=1, OVERFLOW=0, POSITIVE=1. `finished` pulses exactly 18 cycles after the accepting edge.
- MULS a=0xFFFD (−3), b=4 → `high`=0xFFFF, `result`=0xFFF4, OVERFLOW=0, POSITIVE=0, ZERO=0.
- DIVS a=0xFFF9 (−7), b=2 → `result`=0xFFFD, `high`=0xFFFF. Then DIV a=100, b=7 → `result`=14, `high`=2, issued with `start` in the cycle after the first `finished`.
- DIV a=5, b=0 → `result`=0xFFFF, `high`=0x0005, OVERFLOW=1, `finished` 2 cycles after `start`. Then DIVS a=0x8000, b=0xFFFF → `result`=0x8000, `high`=0, OVERFLOW=1.
- Re-assert `start` with new operands during CALC → ignored; the original results are unchanged and `finished` timing is unchanged.
- Pull `RESET_N` low during CALC cycle 5 → `busy`, `finished`, `result`, `high` and `flags` go to 0 immediately. After release, MUL 0×0 → ZERO=1, POSITIVE=0, latency 18.
